// File: rtl/ex_mem_latch.sv
// EX/MEM pipeline latch: two-entry skid buffer between execute and memory,
// with branch redirect to fetch, overflow-trap writeback squash and flush.
module ex_mem_latch #(
  parameter int unsigned REG_SIZE  = 32,
  parameter int unsigned ADDR_SIZE = 32,
  parameter int unsigned DST_W     = 5
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 flush,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [REG_SIZE-1:0]  in_aluresult,
  input  logic                 in_zero,
  input  logic                 in_overflow,
  input  logic [ADDR_SIZE-1:0] in_pc_branch,
  input  logic [DST_W-1:0]     in_dst,
  input  logic [REG_SIZE-1:0]  in_store_data,
  input  logic [4:0]           in_ctl,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [REG_SIZE-1:0]  out_aluresult,
  output logic [REG_SIZE-1:0]  out_store_data,
  output logic [DST_W-1:0]     out_dst,
  output logic                 out_regwrite,
  output logic                 out_memread,
  output logic                 out_memwrite,
  output logic                 out_exc_ovf,
  output logic                 redirect_valid,
  output logic [ADDR_SIZE-1:0] redirect_pc
);

  localparam int unsigned CTL_BRANCH   = 4;
  localparam int unsigned CTL_OV_TRAP  = 3;
  localparam int unsigned CTL_REGWRITE = 2;
  localparam int unsigned CTL_MEMREAD  = 1;
  localparam int unsigned CTL_MEMWRITE = 0;

  typedef struct packed {
    logic [REG_SIZE-1:0] aluresult;
    logic [REG_SIZE-1:0] store_data;
    logic [DST_W-1:0]    dst;
    logic                regwrite;
    logic                memread;
    logic                memwrite;
    logic                exc;
  } entry_t;

  // State registers
  logic                 main_valid;
  logic                 skid_valid;
  logic                 in_ready_q;
  entry_t               main_q;
  entry_t               skid_q;
  logic                 redirect_valid_q;
  logic [ADDR_SIZE-1:0] redirect_pc_q;

  // Next-state / control
  logic   accept_c;
  logic   pop_c;
  logic   exc_c;
  entry_t in_entry_c;
  logic   main_valid_n;
  logic   skid_valid_n;
  logic   in_ready_n;
  logic   main_load;
  logic   main_from_skid;
  logic   skid_load;
  logic   redirect_n;
  logic   rpc_load;

  // Trapping overflow kills architectural side effects but the entry still flows
  assign exc_c = in_overflow & in_ctl[CTL_OV_TRAP];

  always_comb begin
    in_entry_c            = '0;
    in_entry_c.aluresult  = in_aluresult;
    in_entry_c.store_data = in_store_data;
    in_entry_c.dst        = in_dst;
    in_entry_c.regwrite   = in_ctl[CTL_REGWRITE] & ~exc_c;
    in_entry_c.memread    = in_ctl[CTL_MEMREAD];
    in_entry_c.memwrite   = in_ctl[CTL_MEMWRITE] & ~exc_c;
    in_entry_c.exc        = exc_c;
  end

  assign accept_c = in_valid & in_ready_q;
  assign pop_c    = main_valid & out_ready;

  // Buffer control; flush overrides accept and pop
  always_comb begin
    main_valid_n   = main_valid;
    skid_valid_n   = skid_valid;
    main_load      = 1'b0;
    main_from_skid = 1'b0;
    skid_load      = 1'b0;
    redirect_n     = 1'b0;
    rpc_load       = 1'b0;

    if (flush) begin
      main_valid_n = 1'b0;
      skid_valid_n = 1'b0;
    end else begin
      if (accept_c) begin
        if (!main_valid || pop_c) begin
          main_load    = 1'b1;
          main_valid_n = 1'b1;
        end else begin
          skid_load    = 1'b1;
          skid_valid_n = 1'b1;
        end
        if (in_ctl[CTL_BRANCH] && in_zero) begin
          redirect_n = 1'b1;
          rpc_load   = 1'b1;
        end
      end else if (pop_c) begin
        if (skid_valid) begin
          main_from_skid = 1'b1;
          skid_valid_n   = 1'b0;
        end else begin
          main_valid_n = 1'b0;
        end
      end
    end

    in_ready_n = ~skid_valid_n;
  end

  // Valid bits and redirect pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_valid       <= 1'b0;
      skid_valid       <= 1'b0;
      in_ready_q       <= 1'b1;
      redirect_valid_q <= 1'b0;
    end else begin
      main_valid       <= main_valid_n;
      skid_valid       <= skid_valid_n;
      in_ready_q       <= in_ready_n;
      redirect_valid_q <= redirect_n;
    end
  end

  // Data registers only load on capture or skid move to keep outputs stable
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_q        <= '0;
      skid_q        <= '0;
      redirect_pc_q <= '0;
    end else begin
      if (main_load) begin
        main_q <= in_entry_c;
      end else if (main_from_skid) begin
        main_q <= skid_q;
      end
      if (skid_load) begin
        skid_q <= in_entry_c;
      end
      if (rpc_load) begin
        redirect_pc_q <= in_pc_branch;
      end
    end
  end

  assign in_ready       = in_ready_q;
  assign out_valid      = main_valid;
  assign out_aluresult  = main_q.aluresult;
  assign out_store_data = main_q.store_data;
  assign out_dst        = main_q.dst;
  assign out_regwrite   = main_q.regwrite;
  assign out_memread    = main_q.memread;
  assign out_memwrite   = main_q.memwrite;
  assign out_exc_ovf    = main_q.exc;
  assign redirect_valid = redirect_valid_q;
  assign redirect_pc    = redirect_pc_q;

endmodule

// File: tb/tb_ex_mem_latch.sv
// Scoreboard bench for ex_mem_latch: expected entries queued at accept,
// compared at the memory-stage output; redirect pulses tracked alongside.
module tb_ex_mem_latch;

  logic        clk;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_aluresult;
  logic        in_zero;
  logic        in_overflow;
  logic [31:0] in_pc_branch;
  logic [4:0]  in_dst;
  logic [31:0] in_store_data;
  logic [4:0]  in_ctl;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_aluresult;
  logic [31:0] out_store_data;
  logic [4:0]  out_dst;
  logic        out_regwrite;
  logic        out_memread;
  logic        out_memwrite;
  logic        out_exc_ovf;
  logic        redirect_valid;
  logic [31:0] redirect_pc;

  typedef struct packed {
    logic [31:0] alu;
    logic [31:0] sd;
    logic [4:0]  dst;
    logic [3:0]  flags; // {regwrite, memread, memwrite, exc}
  } exp_t;

  exp_t        sb_q[$];
  logic        exp_rv;
  logic [31:0] exp_rpc;
  int          checks;
  int          errors;

  ex_mem_latch #(.REG_SIZE(32), .ADDR_SIZE(32), .DST_W(5)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_aluresult(in_aluresult), .in_zero(in_zero), .in_overflow(in_overflow),
    .in_pc_branch(in_pc_branch), .in_dst(in_dst), .in_store_data(in_store_data),
    .in_ctl(in_ctl),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_aluresult(out_aluresult), .out_store_data(out_store_data), .out_dst(out_dst),
    .out_regwrite(out_regwrite), .out_memread(out_memread), .out_memwrite(out_memwrite),
    .out_exc_ovf(out_exc_ovf),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Scoreboard monitor, sampled on the falling edge
  always @(negedge clk) begin
    if (!rst_n) begin
      sb_q.delete();
      exp_rv = 1'b0;
    end else begin
      chk("out_valid", 64'(out_valid), 64'(sb_q.size() > 0));
      chk("in_ready", 64'(in_ready), 64'(sb_q.size() < 2));
      chk("redirect_valid", 64'(redirect_valid), 64'(exp_rv));
      if (exp_rv) chk("redirect_pc", 64'(redirect_pc), 64'(exp_rpc));
      if (out_valid && sb_q.size() > 0) begin
        chk("out_aluresult", 64'(out_aluresult), 64'(sb_q[0].alu));
        chk("out_store_data", 64'(out_store_data), 64'(sb_q[0].sd));
        chk("out_dst", 64'(out_dst), 64'(sb_q[0].dst));
        chk("out_flags", 64'({out_regwrite, out_memread, out_memwrite, out_exc_ovf}),
            64'(sb_q[0].flags));
      end
      if (flush) begin
        sb_q.delete();
        exp_rv = 1'b0;
      end else begin
        if (out_valid && out_ready && sb_q.size() > 0) void'(sb_q.pop_front());
        exp_rv = 1'b0;
        if (in_valid && in_ready) begin
          exp_t e;
          logic exc;
          exc     = in_overflow & in_ctl[3];
          e.alu   = in_aluresult;
          e.sd    = in_store_data;
          e.dst   = in_dst;
          e.flags = {in_ctl[2] & ~exc, in_ctl[1], in_ctl[0] & ~exc, exc};
          sb_q.push_back(e);
          if (in_ctl[4] && in_zero) begin
            exp_rv  = 1'b1;
            exp_rpc = in_pc_branch;
          end
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [31:0] alu, input logic [4:0] ctl, input logic z,
                      input logic ov, input logic [31:0] pcb);
    in_valid      = 1'b1;
    in_aluresult  = alu;
    in_ctl        = ctl;
    in_zero       = z;
    in_overflow   = ov;
    in_pc_branch  = pcb;
    in_dst        = alu[4:0];
    in_store_data = ~alu;
    step();
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    checks = 0; errors = 0;
    exp_rv = 1'b0; exp_rpc = '0;
    rst_n = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_aluresult = '0; in_zero = 1'b0; in_overflow = 1'b0; in_pc_branch = '0;
    in_dst = '0; in_store_data = '0; in_ctl = '0;
    #2 rst_n = 1'b0;
    #1;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_redirect", 64'(redirect_valid), 64'd0);
    chk("rst_aluresult", 64'(out_aluresult), 64'd0);
    chk("rst_redirect_pc", 64'(redirect_pc), 64'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    step();

    // Streaming
    out_ready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      send(32'(i * 16), 5'b00100, 1'b0, 1'b0, 32'h0);
      chk("stream_in_ready", 64'(in_ready), 64'd1);
      if (i == 1) chk("stream_latency", 64'(out_valid), 64'd1);
    end
    idle(3);

    // Back-pressure
    out_ready = 1'b0;
    send(32'hA, 5'b00100, 1'b0, 1'b0, 32'h0);
    send(32'hB, 5'b00010, 1'b0, 1'b0, 32'h0);
    chk("bp_in_ready", 64'(in_ready), 64'd0);
    chk("bp_main", 64'(out_aluresult), 64'hA);
    idle(2);
    out_ready = 1'b1;
    idle(1);
    chk("bp_ready_back", 64'(in_ready), 64'd1);
    chk("bp_second", 64'(out_aluresult), 64'hB);
    idle(2);

    // Branch taken / not taken
    send(32'h100, 5'b10000, 1'b1, 1'b0, 32'h40);
    chk("br_pulse", 64'(redirect_valid), 64'd1);
    chk("br_pc", 64'(redirect_pc), 64'h40);
    idle(1);
    chk("br_one_cycle", 64'(redirect_valid), 64'd0);
    send(32'h104, 5'b10000, 1'b0, 1'b0, 32'h80);
    chk("br_not_taken", 64'(redirect_valid), 64'd0);
    chk("br_pc_hold", 64'(redirect_pc), 64'h40);
    idle(2);

    // Overflow trap
    send(32'h55, 5'b01111, 1'b0, 1'b1, 32'h0);
    chk("ovf_regwrite", 64'(out_regwrite), 64'd0);
    chk("ovf_memwrite", 64'(out_memwrite), 64'd0);
    chk("ovf_exc", 64'(out_exc_ovf), 64'd1);
    send(32'h66, 5'b00111, 1'b0, 1'b1, 32'h0);
    chk("noov_regwrite", 64'(out_regwrite), 64'd1);
    chk("noov_exc", 64'(out_exc_ovf), 64'd0);
    idle(2);

    // Random traffic with occasional flush (consumer held off during flush)
    for (int i = 0; i < 300; i++) begin
      flush         = ($urandom_range(0, 15) == 0);
      out_ready     = flush ? 1'b0 : 1'($urandom_range(0, 2) != 0);
      in_valid      = 1'($urandom_range(0, 3) != 0);
      in_aluresult  = $urandom;
      in_store_data = $urandom;
      in_dst        = 5'($urandom);
      in_ctl        = 5'($urandom);
      in_zero       = 1'($urandom);
      in_overflow   = 1'($urandom);
      in_pc_branch  = $urandom;
      step();
    end
    flush = 1'b0;
    out_ready = 1'b1;
    idle(4);

    // Flush with buffer full and a taken branch presented
    out_ready = 1'b0;
    send(32'hF1, 5'b00100, 1'b0, 1'b0, 32'h0);
    send(32'hF2, 5'b00100, 1'b0, 1'b0, 32'h0);
    flush = 1'b1;
    send(32'hF3, 5'b10000, 1'b1, 1'b0, 32'h200);
    flush = 1'b0;
    chk("flush_out_valid", 64'(out_valid), 64'd0);
    chk("flush_in_ready", 64'(in_ready), 64'd1);
    chk("flush_no_redirect", 64'(redirect_valid), 64'd0);
    idle(2);

    // Async reset mid-stall with skid full and a redirect pulsing
    send(32'hC1, 5'b00100, 1'b0, 1'b0, 32'h0);
    send(32'hC2, 5'b10000, 1'b1, 1'b0, 32'h99);
    chk("pre_rst_full", 64'(in_ready), 64'd0);
    chk("pre_rst_redirect", 64'(redirect_valid), 64'd1);
    #1 rst_n = 1'b0;
    #1;
    chk("arst_out_valid", 64'(out_valid), 64'd0);
    chk("arst_redirect", 64'(redirect_valid), 64'd0);
    chk("arst_in_ready", 64'(in_ready), 64'd1);
    @(negedge clk);
    #1 rst_n = 1'b1;
    out_ready = 1'b1;
    step();
    send(32'hD1, 5'b00100, 1'b0, 1'b0, 32'h0);
    idle(3);
    chk("drain_empty", 64'(sb_q.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ex_mem_latch.md
Name: ex_mem_latch

Overview:
- Receiving end of the execute-stage result interface. Registers ALU result, flags, branch target and destination register from execute and presents them to the memory stage.
- Two-entry skid buffer with valid/ready handshakes on both sides, so memory-stage stalls never drop an execute result.
- Resolves conditional branches: a one-cycle redirect (target PC) to fetch.
- Squashes register writeback on trapping overflow; provides a synchronous flush.

Parameters:
- REG_SIZE, 32, data width of ALU result and store data
- ADDR_SIZE, 32, width of branch target PC
- DST_W, 5, destination register index width

Ports:
- clk  in  1  clock; all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- flush  in  1  synchronous squash of all held entries
- in_valid  in  1  execute result valid
- in_ready  out  1  latch can accept this cycle
- in_aluresult  in  REG_SIZE  ALU output
- in_zero  in  1  ALU zero flag
- in_overflow  in  1  ALU overflow flag
- in_pc_branch  in  ADDR_SIZE  computed branch target
- in_dst  in  DST_W  destination register
- in_store_data  in  REG_SIZE  rt value for stores
- in_ctl  in  5  {branch, ov_trap, regwrite, memread, memwrite}, MSB first
- out_valid  out  1  entry presented to memory stage
- out_ready  in  1  memory stage consumes when out_valid & out_ready
- out_aluresult  out  REG_SIZE
- out_store_data  out  REG_SIZE
- out_dst  out  DST_W
- out_regwrite, out_memread, out_memwrite  out  1 each
- out_exc_ovf  out  1  entry carries a trapping overflow
- redirect_valid  out  1  one-cycle branch-taken pulse to fetch
- redirect_pc  out  ADDR_SIZE  target for redirect

Behaviour:
- Reset (rst_n low, async): main_valid=0, skid_valid=0, in_ready=1, out_valid=0, redirect_valid=0. All data outputs and redirect_pc are 0.
- Storage:
  - main register drives the out_* ports.
  - skid register holds one overflow entry.
  - in_ready = !skid_valid, driven directly from a flop.
- Accept occurs when in_valid & in_ready.
- Pop occurs when out_valid & out_ready.
- Accept handling:
  - main empty, or popping this cycle: the entry loads into main; skid is unchanged.
  - main full and not popping: the entry loads into skid.
- Pop with skid full and no accept: skid moves to main; skid_valid drops to 0.
- Pop with skid full: in_ready is 0, so no simultaneous accept is possible.
- Latency: accept to out_valid is 1 cycle. Throughput is 1 per cycle while out_ready=1.
- Ordering is strictly FIFO (skid is always older than the next input).
- Entry transform at capture:
  - exc = in_overflow & ov_trap.
  - stored regwrite = regwrite & !exc.
  - stored memwrite = memwrite & !exc.
  - out_exc_ovf = exc.
- Branch redirect:
  - On accept with branch & in_zero, the next cycle has redirect_valid=1 and redirect_pc=in_pc_branch. Otherwise redirect_valid=0.
  - redirect_pc holds its last value when not pulsing.
  - Redirect is issued at accept regardless of back-pressure. The branch entry itself still flows through the buffer.
- Flush:
  - Next edge: main_valid=0, skid_valid=0, in_ready=1.
  - An accept in the flush cycle is discarded and produces no redirect.
  - A redirect already pulsing in that cycle is not cancelled.
  - Flush has priority over accept and pop.
- Reset mid-operation: immediate clear of all valid bits and redirect_valid. No partial entries survive.
- Data registers load only on accept or skid-move, not on idle cycles. This keeps power low and keeps outputs stable while out_valid & !out_ready.

Test Plan:
- Streaming: out_ready=1; send 4 entries with aluresult 0x10, 0x20, 0x30, 0x40 back-to-back -> out_valid from cycle 1, same order, one per cycle, in_ready stays 1.
- Back-pressure: out_ready=0; send 0xA then 0xB -> main=0xA, skid=0xB, in_ready=0 at cycle 2. Raise out_ready -> 0xA then 0xB delivered, in_ready returns to 1 the cycle after the first pop.
- Branch: ctl branch=1, zero=1, pc_branch=0x0040 -> redirect_valid=1 with redirect_pc=0x0040 exactly one cycle after accept. Same with zero=0 -> no pulse.
- Overflow trap: ov_trap=1, overflow=1, regwrite=1, memwrite=1 -> out_regwrite=0, out_memwrite=0, out_exc_ovf=1. Same with ov_trap=0 -> regwrite=1, exc=0.
- Flush with buffer full plus simultaneous valid input (branch taken) -> next cycle out_valid=0, in_ready=1, no redirect pulse.
- Async reset asserted mid-stall with skid full -> out_valid, redirect_valid and in_ready reach 0/0/1 before the next clock edge.
